fetch_pc_unit: RTL

Program-counter and instruction-fetch sequencer. It is the consumer end of the branch-resolution interface (BranchResultEn/BranchAddr). It issues fetch requests to the instruction memory port and hands instructions to the decoder over a valid/ready handshake. There is no branch prediction: after a conditional branch or JALR is handed over, fetch stalls until the branch unit returns the resolved target.

---
 rtl/fetch_pc_unit_pkg.sv | 27 ++
 rtl/fetch_predecode.sv | 20 ++
 rtl/fetch_pc_unit.sv | 101 ++++++++++
 3 files changed

// File: rtl/fetch_pc_unit_pkg.sv
// Shared constants, opcode values and state encoding for the fetch/PC sequencer.
package fetch_pc_unit_pkg;

    localparam int unsigned INST_ADDR_BUS = 32;
    localparam int unsigned INST_BUS      = 32;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    localparam logic [INST_ADDR_BUS-1:0] ADDR_FREE = '0;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_HOLD    = 2'd1,
        ST_WAIT_BR = 2'd2
    } fetch_state_t;

    // Reassemble the scattered J-type immediate from instruction bits [31:12].
    function automatic logic [20:0] j_imm(input logic [19:0] upper);
        return {upper[19], upper[7:0], upper[8], upper[18:9], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_predecode.sv
// Combinational opcode classification and JAL target offset extraction.
module fetch_predecode
    import fetch_pc_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [6:0]            opcode,
    input  logic [19:0]           imm_field,
    output logic                  is_branch_wait,
    output logic                  is_jal,
    output logic [ADDR_WIDTH-1:0] jal_offset
);

    always_comb begin
        is_branch_wait = (opcode == OP_BRANCH) || (opcode == OP_JALR);
        is_jal         = (opcode == OP_JAL);
        jal_offset     = ADDR_WIDTH'($signed(j_imm(imm_field)));
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter and single-outstanding instruction fetch sequencer (no prediction).
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter int                    ADDR_WIDTH = INST_ADDR_BUS,
    parameter int                    INST_WIDTH = INST_BUS,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  BranchResultEn,
    input  logic [ADDR_WIDTH-1:0] BranchAddr,
    output logic                  FetchReq,
    output logic [ADDR_WIDTH-1:0] FetchAddr,
    input  logic                  FetchAck,
    input  logic [INST_WIDTH-1:0] FetchInst,
    output logic                  InstValid,
    output logic [INST_WIDTH-1:0] Inst,
    output logic [ADDR_WIDTH-1:0] InstPC,
    input  logic                  DecReady
);

    localparam logic [ADDR_WIDTH-1:0] INST_BYTES = ADDR_WIDTH'(4);

    fetch_state_t          state, state_d;
    logic [ADDR_WIDTH-1:0] pc, pc_d;
    logic [INST_WIDTH-1:0] inst_q;
    logic [ADDR_WIDTH-1:0] inst_pc_q;
    logic                  armed;
    logic                  load_inst;
    logic                  is_branch_wait;
    logic                  is_jal;
    logic [ADDR_WIDTH-1:0] jal_offset;

    fetch_predecode #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_predecode (
        .opcode        (inst_q[6:0]),
        .imm_field     (inst_q[31:12]),
        .is_branch_wait(is_branch_wait),
        .is_jal        (is_jal),
        .jal_offset    (jal_offset)
    );

    // armed holds the request off for the first cycle after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_FETCH;
            pc        <= RESET_PC;
            inst_q    <= '0;
            inst_pc_q <= '0;
            armed     <= DISABLE;
        end else begin
            state <= state_d;
            pc    <= pc_d;
            armed <= ENABLE;
            if (load_inst) begin
                inst_q    <= FetchInst;
                inst_pc_q <= pc;
            end
        end
    end

    always_comb begin
        state_d   = state;
        pc_d      = pc;
        load_inst = 1'b0;
        case (state)
            ST_FETCH: begin
                if (armed && FetchAck) begin
                    load_inst = 1'b1;
                    state_d   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (DecReady) begin
                    if (is_branch_wait) begin
                        state_d = ST_WAIT_BR;
                    end else begin
                        state_d = ST_FETCH;
                        pc_d    = is_jal ? (inst_pc_q + jal_offset) : (inst_pc_q + INST_BYTES);
                    end
                end
            end
            ST_WAIT_BR: begin
                if (BranchResultEn) begin
                    pc_d    = BranchAddr;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    assign FetchReq  = armed && (state == ST_FETCH);
    assign FetchAddr = pc;
    assign InstValid = (state == ST_HOLD);
    assign Inst      = inst_q;
    assign InstPC    = inst_pc_q;

endmodule
